// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the 2:1 stream arbiter.
//   src_e : source id, doubles as the downstream mux select (0 = A, 1 = B)
//   occ_e : occupancy of the one-entry output register
package mux2_arb_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef enum logic {
    EMPTY,
    FULL
  } occ_e;

  localparam int unsigned DefaultDataW = 8;

endpackage

// File: rtl/mux2_arb_out_reg.sv
// One-entry valid/ready output register.
// Accepts a new entry when empty or when the held entry leaves in the same cycle,
// so a steady stream passes at one beat per cycle without bubbles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data registered payload
module mux2_arb_out_reg
  import mux2_arb_pkg::*;
#(
  parameter int unsigned Width = DefaultDataW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  occ_e             occ_q, occ_d;
  logic [Width-1:0] data_q, data_d;
  logic             load;

  always_comb begin
    // Gated by reset so nothing looks accepted while the register is being cleared.
    in_ready = rst_n && ((occ_q == EMPTY) || out_ready);
    load     = in_valid && in_ready;
    occ_d    = occ_q;
    data_d   = data_q;
    case (occ_q)
      EMPTY:   if (load) occ_d = FULL;
      FULL:    if (out_ready && !load) occ_d = EMPTY;
      default: occ_d = EMPTY;
    endcase
    if (load) data_d = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= EMPTY;
      data_q <= '0;
    end else begin
      occ_q  <= occ_d;
      data_q <= data_d;
    end
  end

  assign out_valid = (occ_q == FULL);
  assign out_data  = data_q;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin arbiter merging two valid/ready streams (A, B) into one registered
// output beat plus the select bit (out_src) that steers the downstream 2:1 mux.
// Optional packet lock: define MUX2_ARB_PKT_LOCK_EN to add a_last/b_last; a granted
// source then keeps the grant until its last beat is accepted.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   a_valid/a_ready/a_data(/a_last) source A stream
//   b_valid/b_ready/b_data(/b_last) source B stream
//   out_valid/out_ready/out_data  registered output stream
//   out_src                       id of the source that produced out_data
module mux2_stream_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter logic        RESET_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
`ifdef MUX2_ARB_PKT_LOCK_EN
  input  logic              a_last,
  input  logic              b_last,
`endif
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
);

  src_e            prio_q, prio_d;
  src_e            gnt_src;
  logic            grant_a, grant_b, gnt_valid;
  logic            can_load, accept;
  logic [DATA_W:0] load_data, held_data;

`ifdef MUX2_ARB_PKT_LOCK_EN
  logic lock_q, lock_d;
  src_e lock_src_q, lock_src_d;
  logic gnt_last;
`endif

  always_comb begin
    grant_a = a_valid && (!b_valid || (prio_q == SRC_A));
    grant_b = b_valid && (!a_valid || (prio_q == SRC_B));
`ifdef MUX2_ARB_PKT_LOCK_EN
    // Inside a packet only the owner may be granted, even if it is idle.
    if (lock_q) begin
      grant_a = a_valid && (lock_src_q == SRC_A);
      grant_b = b_valid && (lock_src_q == SRC_B);
    end
`endif
  end

  assign gnt_valid = grant_a || grant_b;
  assign gnt_src   = grant_b ? SRC_B : SRC_A;
  assign load_data = grant_b ? {1'b1, b_data} : {1'b0, a_data};
  assign accept    = gnt_valid && can_load;
  assign a_ready   = can_load && grant_a;
  assign b_ready   = can_load && grant_b;

`ifdef MUX2_ARB_PKT_LOCK_EN
  assign gnt_last = grant_b ? b_last : a_last;
`endif

  always_comb begin
    prio_d = prio_q;
`ifdef MUX2_ARB_PKT_LOCK_EN
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (accept) begin
      if (gnt_last) begin
        lock_d = 1'b0;
        prio_d = src_e'(~gnt_src);
      end else begin
        lock_d     = 1'b1;
        lock_src_d = gnt_src;
      end
    end
`else
    if (accept) prio_d = src_e'(~gnt_src);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= src_e'(RESET_PRIO);
    end else begin
      prio_q <= prio_d;
    end
  end

`ifdef MUX2_ARB_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_A;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end
`endif

  // Source id travels as the MSB so select and payload are always registered together.
  mux2_arb_out_reg #(
    .Width(DATA_W + 1)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (gnt_valid),
    .in_ready (can_load),
    .in_data  (load_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (held_data)
  );

  assign out_data = held_data[DATA_W-1:0];
  assign out_src  = held_data[DATA_W];

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: directed scenarios plus randomized traffic,
// each cycle compared against a reference model of the arbitration rules.
module tb_mux2_stream_arbiter;

`ifdef MUX2_ARB_PKT_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif
  localparam bit ResetPrio = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic       a_last = 1'b1, b_last = 1'b1;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, out_valid, out_src;
  logic [7:0] out_data;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state: what the output register should hold, who is favoured.
  bit       m_full;
  bit [7:0] m_data;
  bit       m_src;
  bit       m_prio;
  bit       m_lock;
  bit       m_lock_src;

  always #5 clk = ~clk;

  mux2_stream_arbiter #(
    .DATA_W    (8),
    .RESET_PRIO(ResetPrio)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
`ifdef MUX2_ARB_PKT_LOCK_EN
    .a_last   (a_last),
    .b_last   (b_last),
`endif
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Holds reset for 3 cycles; returns at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_src", out_src, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("rst_a_ready", a_ready, 0);
      check_eq("rst_b_ready", b_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
    end
    m_full = 0;
    m_data = 0;
    m_src  = 0;
    m_prio = ResetPrio;
    m_lock = 0;
    m_lock_src = 0;
    rst_n = 1'b1;
  endtask

  // Called at posedge+1 with inputs already driven; checks this cycle, advances the model.
  task automatic step();
    bit can_load, gv, gs, acc, lst;
    #1;
    can_load = !m_full || out_ready;
    gv = 0;
    gs = 0;
    if (m_lock) begin
      gs = m_lock_src;
      gv = gs ? b_valid : a_valid;
    end else if (a_valid && b_valid) begin
      gv = 1;
      gs = m_prio;
    end else if (a_valid || b_valid) begin
      gv = 1;
      gs = b_valid;
    end
    acc = can_load && gv;
    check_eq("a_ready", a_ready, acc && !gs);
    check_eq("b_ready", b_ready, acc && gs);
    check_eq("out_valid", out_valid, m_full);
    if (m_full) begin
      check_eq("out_data", out_data, m_data);
      check_eq("out_src", out_src, m_src);
    end
    lst = gs ? b_last : a_last;
    @(posedge clk);
    if (m_full && out_ready && !acc) m_full = 0;
    if (acc) begin
      m_full = 1;
      m_data = gs ? b_data : a_data;
      m_src  = gs;
      if (!LockEn || lst) begin
        m_lock = 0;
        m_prio = !gs;
      end else begin
        m_lock = 1;
        m_lock_src = gs;
      end
    end
    #1;
  endtask

  initial begin
    // Reset with both sources offering beats.
    a_valid = 1; b_valid = 1; a_data = 8'h11; b_data = 8'h22; out_ready = 1;
    #2;
    do_reset();

    // Alternation A,B,A,... at full rate.
    repeat (8) step();
    check_eq("alt_src_seen", out_valid, 1);

    // Backpressure: A's 0x33 held while B waits.
    a_valid = 0; b_valid = 0; out_ready = 1;
    do_reset();
    a_valid = 1; a_data = 8'h33; out_ready = 0;
    step();
    a_valid = 0; b_valid = 1; b_data = 8'h44;
    repeat (5) step();
    check_eq("bp_hold_data", out_data, 8'h33);
    out_ready = 1;
    step();
    step();

    // Single source B, then both: A should win next.
    a_valid = 0; b_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      b_data = 8'(i);
      step();
    end
    a_valid = 1; a_data = 8'h5a; b_data = 8'h6b;
    step();
    step();
    step();

`ifdef MUX2_ARB_PKT_LOCK_EN
    // Packet lock: A's 3-beat packet with an idle gap, B valid throughout.
    a_valid = 0; b_valid = 0;
    do_reset();
    out_ready = 1; b_valid = 1; b_data = 8'h55; b_last = 1;
    a_valid = 1; a_last = 0; a_data = 8'ha1;
    step();
    a_data = 8'ha2;
    step();
    a_valid = 0;
    step();
    check_eq("lock_b_blocked", b_ready, 0);
    a_valid = 1; a_last = 1; a_data = 8'ha3;
    step();
    a_valid = 0;
    step();
    step();
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      a_data    = 8'($urandom);
      b_data    = 8'($urandom);
      a_last    = ($urandom_range(0, 2) == 0);
      b_last    = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Mid-operation reset drops the held beat without a clock edge.
    a_last = 1; b_last = 1;
    a_valid = 0; b_valid = 0; out_ready = 1;
    step();
    step();
    a_valid = 1; a_data = 8'h77; out_ready = 0;
    step();
    check_eq("midrst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid_async", out_valid, 0);
    do_reset();
    a_valid = 1; b_valid = 1; a_data = 8'h81; b_data = 8'h82; out_ready = 1;
    step();
    step();
    check_eq("postrst_first_src", out_src, 1);
    step();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
